id_ex_stage: RTL

- ID/EX pipeline stage; sits directly upstream of the ALU wrapper and feeds its src1_i, src2_i and ctrl_i.
- Registers decoded operands and controls.
- Resolves EX/MEM and MEM/WB forwarding onto the ALU operands.
- Detects load-use hazards, stalls IF/ID and injects a bubble.
- Supports a downstream hold and a branch flush.

---
 rtl/id_ex_stage.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// downstream hold and branch flush. Feeds the ALU wrapper directly.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              id_valid_i,
   input  logic [DATA_W-1:0] id_rs_data_i,
   input  logic [DATA_W-1:0] id_rt_data_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [REG_AW-1:0] id_rs_addr_i,
   input  logic [REG_AW-1:0] id_rt_addr_i,
   input  logic [REG_AW-1:0] id_rd_addr_i,
   input  logic [CTRL_W-1:0] id_alu_ctrl_i,
   input  logic              id_alusrc_i,
   input  logic              id_shift_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              id_memwrite_i,

   input  logic              hold_i,
   input  logic              flush_i,

   input  logic              exm_regwrite_i,
   input  logic [REG_AW-1:0] exm_rd_i,
   input  logic [DATA_W-1:0] exm_result_i,
   input  logic              mwb_regwrite_i,
   input  logic [REG_AW-1:0] mwb_rd_i,
   input  logic [DATA_W-1:0] mwb_data_i,

   output logic              stall_o,
   output logic              ex_valid_o,
   output logic [DATA_W-1:0] ex_src1_o,
   output logic [DATA_W-1:0] ex_src2_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [DATA_W-1:0] ex_store_data_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic              ex_regwrite_o,
   output logic              ex_memread_o,
   output logic              ex_memwrite_o
);

   logic              ex_valid_q;
   logic              ex_regwrite_q;
   logic              ex_memread_q;
   logic              ex_memwrite_q;
   logic              ex_alusrc_q;
   logic              ex_shift_q;
   logic [CTRL_W-1:0] ex_ctrl_q;
   logic [REG_AW-1:0] ex_rd_q;
   logic [REG_AW-1:0] ex_rs_addr_q;
   logic [REG_AW-1:0] ex_rt_addr_q;
   logic [DATA_W-1:0] ex_rs_data_q;
   logic [DATA_W-1:0] ex_rt_data_q;
   logic [DATA_W-1:0] ex_imm_q;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic              uses_rt;
   logic              hazard;

   // EX/MEM wins over MEM/WB because it carries the younger write; $0 is never bypassed.
   always_comb begin
      fwd_rs = ex_rs_data_q;
      if (exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == ex_rs_addr_q))
         fwd_rs = exm_result_i;
      else if (mwb_regwrite_i && (mwb_rd_i != '0) && (mwb_rd_i == ex_rs_addr_q))
         fwd_rs = mwb_data_i;
   end

   always_comb begin
      fwd_rt = ex_rt_data_q;
      if (exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == ex_rt_addr_q))
         fwd_rt = exm_result_i;
      else if (mwb_regwrite_i && (mwb_rd_i != '0) && (mwb_rd_i == ex_rt_addr_q))
         fwd_rt = mwb_data_i;
   end

   // Shifts take shamt through src1 and the shifted value (rt) through src2.
   always_comb begin
      ex_src1_o = ex_shift_q ? ex_imm_q : fwd_rs;
      ex_src2_o = (ex_alusrc_q && !ex_shift_q) ? ex_imm_q : fwd_rt;
   end

   assign ex_store_data_o = fwd_rt;
   assign ex_valid_o      = ex_valid_q;
   assign ex_ctrl_o       = ex_ctrl_q;
   assign ex_rd_o         = ex_rd_q;
   assign ex_regwrite_o   = ex_regwrite_q;
   assign ex_memread_o    = ex_memread_q;
   assign ex_memwrite_o   = ex_memwrite_q;

   // A load in EX cannot feed the instruction in ID in time; rt only matters if actually read.
   assign uses_rt = !id_alusrc_i || id_memwrite_i || id_shift_i;
   assign hazard  = ex_valid_q && ex_memread_q && (ex_rd_q != '0) && id_valid_i &&
                    ((ex_rd_q == id_rs_addr_i) || (uses_rt && (ex_rd_q == id_rt_addr_i)));
   assign stall_o = hazard || hold_i;

   // Hold refreshes the operand data so write-backs retiring during the freeze are captured.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_valid_q    <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_memwrite_q <= 1'b0;
         ex_alusrc_q   <= 1'b0;
         ex_shift_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_rd_q       <= '0;
         ex_rs_addr_q  <= '0;
         ex_rt_addr_q  <= '0;
         ex_rs_data_q  <= '0;
         ex_rt_data_q  <= '0;
         ex_imm_q      <= '0;
      end else if (hold_i) begin
         ex_rs_data_q  <= fwd_rs;
         ex_rt_data_q  <= fwd_rt;
      end else if (flush_i || hazard) begin
         ex_valid_q    <= 1'b0;
         ex_regwrite_q <= 1'b0;
         ex_memread_q  <= 1'b0;
         ex_memwrite_q <= 1'b0;
         ex_alusrc_q   <= 1'b0;
         ex_shift_q    <= 1'b0;
         ex_ctrl_q     <= '0;
         ex_rd_q       <= '0;
         ex_rs_addr_q  <= '0;
         ex_rt_addr_q  <= '0;
         ex_rs_data_q  <= '0;
         ex_rt_data_q  <= '0;
         ex_imm_q      <= '0;
      end else begin
         ex_valid_q    <= id_valid_i;
         ex_regwrite_q <= id_valid_i && id_regwrite_i;
         ex_memread_q  <= id_valid_i && id_memread_i;
         ex_memwrite_q <= id_valid_i && id_memwrite_i;
         ex_alusrc_q   <= id_alusrc_i;
         ex_shift_q    <= id_shift_i;
         ex_ctrl_q     <= id_alu_ctrl_i;
         ex_rd_q       <= id_rd_addr_i;
         ex_rs_addr_q  <= id_rs_addr_i;
         ex_rt_addr_q  <= id_rt_addr_i;
         ex_rs_data_q  <= id_rs_data_i;
         ex_rt_data_q  <= id_rt_data_i;
         ex_imm_q      <= id_imm_i;
      end
   end

endmodule
